// File: rtl/result_uart_tx.sv
// Serial reporter: on a rising edge of finish, latches the 32-bit result and
// sends it as eight uppercase ASCII hex digits plus CR LF over an 8N1 UART line.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        finish,
  input  logic [31:0] result,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BYTE = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [31:0]   latched_q, latched_d;
  logic          finish_q;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          baud_end;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] msg_byte(input logic [31:0] val, input logic [3:0] idx);
    case (idx)
      4'd0:    return hex_ascii(val[31:28]);
      4'd1:    return hex_ascii(val[27:24]);
      4'd2:    return hex_ascii(val[23:20]);
      4'd3:    return hex_ascii(val[19:16]);
      4'd4:    return hex_ascii(val[15:12]);
      4'd5:    return hex_ascii(val[11:8]);
      4'd6:    return hex_ascii(val[7:4]);
      4'd7:    return hex_ascii(val[3:0]);
      4'd8:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    latched_d  = latched_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (finish && !finish_q) begin
          latched_d  = result;
          byte_idx_d = 4'd0;
          bit_idx_d  = 3'd0;
          baud_d     = '0;
          busy_d     = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_idx_q < LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = S_START;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is registered, so it is derived from the next state to line up with busy.
  assign cur_byte = msg_byte(latched_d, byte_idx_d);

  always_comb begin
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous here.
    if (reset) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      baud_q     <= '0;
      latched_q  <= 32'd0;
      finish_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      latched_q  <= latched_d;
      finish_q   <= finish;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: a fast-baud instance for functional corners and a
// 868-clock instance run in parallel for exact slow-bit timing.
module tb_result_uart_tx;

  localparam int FAST_CPB = 4;
  localparam int SLOW_CPB = 868;

  logic        clk;
  logic        reset_f, finish_f, tx_f, busy_f, done_f;
  logic [31:0] result_f;
  logic        reset_s, finish_s, tx_s, busy_s, done_s;
  logic [31:0] result_s;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] res;
    logic [79:0] exp;
  } vec_t;

  vec_t vecs[8];

  logic [7:0] exp_f_q[$];
  logic [7:0] exp_s_q[$];

  result_uart_tx #(.CLKS_PER_BIT(FAST_CPB)) u_fast (
    .clk(clk), .reset(reset_f), .finish(finish_f), .result(result_f),
    .tx(tx_f), .busy(busy_f), .done(done_f)
  );

  result_uart_tx #(.CLKS_PER_BIT(SLOW_CPB)) u_slow (
    .clk(clk), .reset(reset_s), .finish(finish_s), .result(result_s),
    .tx(tx_s), .busy(busy_s), .done(done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic get_tx(input int sel);
    return (sel == 0) ? tx_f : tx_s;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_f : busy_s;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 0) ? done_f : done_s;
  endfunction

  task automatic push_exp(input int sel, input logic [79:0] e);
    for (int i = 0; i < 10; i++) begin
      if (sel == 0) exp_f_q.push_back(e[79-8*i -: 8]);
      else          exp_s_q.push_back(e[79-8*i -: 8]);
    end
  endtask

  task automatic pop_exp(input int sel, output logic [7:0] b);
    b = 8'hxx;
    if (sel == 0) begin
      if (exp_f_q.size() > 0) b = exp_f_q.pop_front();
    end else begin
      if (exp_s_q.size() > 0) b = exp_s_q.pop_front();
    end
  endtask

  // Called on the negedge where the trigger was driven; decodes one full frame.
  task automatic recv_msg(input int sel, input int cpb, input string tag);
    int         lat, steady_err, ctrl_err, frame_err;
    logic       v;
    logic [7:0] data, expb;
    lat = 0; steady_err = 0; ctrl_err = 0; frame_err = 0; v = 1'b1; data = 8'h00;
    do begin
      @(negedge clk);
      lat++;
    end while (get_tx(sel) === 1'b1 && lat < 20);
    check({tag, " start latency"}, lat, 1);
    if (get_tx(sel) !== 1'b0) return;
    for (int by = 0; by < 10; by++) begin
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < cpb; c++) begin
          if (!(by == 0 && k == 0 && c == 0)) @(negedge clk);
          if (c == 0) v = get_tx(sel);
          else if (get_tx(sel) !== v) steady_err++;
          if (get_busy(sel) !== 1'b1 || get_done(sel) !== 1'b0) ctrl_err++;
        end
        if (k == 0 && v !== 1'b0) frame_err++;
        if (k == 9 && v !== 1'b1) frame_err++;
        if (k >= 1 && k <= 8) data[k-1] = v;
      end
      pop_exp(sel, expb);
      check($sformatf("%s byte %0d", tag, by), {24'h0, data}, {24'h0, expb});
    end
    @(negedge clk);
    check({tag, " end done/busy/tx"}, {29'h0, get_done(sel), get_busy(sel), get_tx(sel)}, 32'h5);
    @(negedge clk);
    check({tag, " done one cycle"}, {31'h0, get_done(sel)}, 32'h0);
    check({tag, " bit steady"}, steady_err, 0);
    check({tag, " busy/done in msg"}, ctrl_err, 0);
    check({tag, " framing"}, frame_err, 0);
  endtask

  task automatic fast_seq();
    int errs, lat;
    repeat (3) @(negedge clk);
    check("reset tx/busy/done", {29'h0, tx_f, busy_f, done_f}, 32'h4);
    reset_f = 1'b0;
    @(negedge clk);

    // Table-driven messages; between entries finish drops for one cycle.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk);
        finish_f = 1'b0;
      end
      @(negedge clk);
      result_f = vecs[i].res;
      finish_f = 1'b1;
      push_exp(0, vecs[i].exp);
      recv_msg(0, FAST_CPB, $sformatf("vec%0d", i));
      if (i == 0) begin
        errs = 0;
        repeat (1000) begin
          @(negedge clk);
          if (tx_f !== 1'b1 || busy_f !== 1'b0 || done_f !== 1'b0) errs++;
        end
        check("held finish no retrigger", errs, 0);
      end
    end

    // Inputs change during byte 3: latched value must win, no extra message.
    @(negedge clk);
    finish_f = 1'b0;
    @(negedge clk);
    result_f = vecs[5].res;
    finish_f = 1'b1;
    push_exp(0, vecs[5].exp);
    fork
      recv_msg(0, FAST_CPB, "midchg");
      begin
        repeat (3 * 10 * FAST_CPB + 5) @(negedge clk);
        result_f = 32'hFFFF_FFFF;
        finish_f = 1'b0;
        @(negedge clk);
        finish_f = 1'b1;
      end
    join
    errs = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_f !== 1'b1 || done_f !== 1'b0 || busy_f !== 1'b0) errs++;
    end
    check("midchg no queued msg", errs, 0);

    // Reset during the data bits of byte 5, finish kept high across release.
    @(negedge clk);
    finish_f = 1'b0;
    @(negedge clk);
    result_f = vecs[6].res;
    finish_f = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (tx_f === 1'b1 && lat < 20);
    check("rst-run start latency", lat, 1);
    errs = 0;
    repeat (52 * FAST_CPB) begin
      @(negedge clk);
      if (done_f !== 1'b0) errs++;
    end
    check("rst-run no early done", errs, 0);
    reset_f  = 1'b1;
    result_f = vecs[7].res;
    @(negedge clk);
    reset_f = 1'b0;
    check("after mid reset tx/busy/done", {29'h0, tx_f, busy_f, done_f}, 32'h4);
    push_exp(0, vecs[7].exp);
    recv_msg(0, FAST_CPB, "restart");
  endtask

  task automatic slow_seq();
    repeat (3) @(negedge clk);
    check("slow reset tx/busy/done", {29'h0, tx_s, busy_s, done_s}, 32'h4);
    reset_s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    result_s = vecs[4].res;
    finish_s = 1'b1;
    push_exp(1, vecs[4].exp);
    recv_msg(1, SLOW_CPB, "slow");
  endtask

  initial begin
    vecs[0] = '{res: 32'h0000_00FF, exp: {"000000FF", 8'h0D, 8'h0A}};
    vecs[1] = '{res: 32'hDEAD_BEEF, exp: {"DEADBEEF", 8'h0D, 8'h0A}};
    vecs[2] = '{res: 32'h0F1E_2D3C, exp: {"0F1E2D3C", 8'h0D, 8'h0A}};
    vecs[3] = '{res: 32'h0000_0000, exp: {"00000000", 8'h0D, 8'h0A}};
    vecs[4] = '{res: 32'h0000_0001, exp: {"00000001", 8'h0D, 8'h0A}};
    vecs[5] = '{res: 32'h1234_5678, exp: {"12345678", 8'h0D, 8'h0A}};
    vecs[6] = '{res: 32'hCAFE_0123, exp: {"CAFE0123", 8'h0D, 8'h0A}};
    vecs[7] = '{res: 32'h8000_00A9, exp: {"800000A9", 8'h0D, 8'h0A}};

    reset_f = 1'b1; finish_f = 1'b0; result_f = 32'h0;
    reset_s = 1'b1; finish_s = 1'b0; result_s = 32'h0;

    fork
      fast_seq();
      slow_seq();
    join

    check("fast scoreboard drained", exp_f_q.size(), 0);
    check("slow scoreboard drained", exp_s_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
